// File: rtl/mmio_pkg.sv
// Shared constants for the UART MMIO window: region tag, register offsets
// and the bit positions inside the status word.
package mmio_pkg;

  // Upper address nibble that selects the I/O window.
  localparam logic [3:0] MMIO_REGION = 4'h8;

  // Register offsets within the window.
  localparam logic [7:0] MMIO_STATUS  = 8'h00;
  localparam logic [7:0] MMIO_RX      = 8'h04;
  localparam logic [7:0] MMIO_TX      = 8'h08;
  localparam logic [7:0] MMIO_CYCLE   = 8'h10;
  localparam logic [7:0] MMIO_INSTRET = 8'h14;
  localparam logic [7:0] MMIO_CNT_RST = 8'h18;

  // Status word bit positions.
  localparam int STAT_TX_NOT_FULL  = 0;
  localparam int STAT_RX_NOT_EMPTY = 1;
  localparam int STAT_TX_OVERFLOW  = 2;

endpackage

// File: rtl/sync_fifo.sv
// Small synchronous FIFO with first-word-fall-through output.
// DEPTH must be a power of two and at least 2. Pointers carry one extra
// wrap bit so full and empty can be told apart. A push while full or a pop
// while empty is ignored, so callers may drive push/pop unconditionally.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic             full,
  output logic             empty
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] PTR_ONE = 1;

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [AW:0]      r_wrPtr;
  logic [AW:0]      r_rdPtr;
  logic             w_doPush;
  logic             w_doPop;

  assign empty    = (r_wrPtr == r_rdPtr);
  assign full     = (r_wrPtr[AW] != r_rdPtr[AW]) &&
                    (r_wrPtr[AW-1:0] == r_rdPtr[AW-1:0]);
  assign w_doPush = push && !full;
  assign w_doPop  = pop && !empty;
  assign dout     = r_mem[r_rdPtr[AW-1:0]];

  // Advance read/write pointers; reset empties the FIFO.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_wrPtr <= '0;
      r_rdPtr <= '0;
    end else begin
      if (w_doPush) r_wrPtr <= r_wrPtr + PTR_ONE;
      if (w_doPop)  r_rdPtr <= r_rdPtr + PTR_ONE;
    end
  end

  // Storage write; contents need no reset because the pointers guard them.
  always_ff @(posedge clk) begin
    if (w_doPush) r_mem[r_wrPtr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/uart_mmio_ctrl.sv
// Memory-mapped UART controller: decodes CPU loads/stores in the 0x8xxx_xxxx
// window, buffers TX/RX bytes in FIFOs, drives the UART ready/valid
// handshakes, and keeps the cycle and retired-instruction counters.
module uart_mmio_ctrl
  import mmio_pkg::*;
#(
  parameter int TX_DEPTH = 8,
  parameter int RX_DEPTH = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] addr,
  input  logic        re,
  input  logic        we,
  input  logic [31:0] wdata,
  output logic [31:0] rdata,
  input  logic        inst_retired,
  output logic [7:0]  tx_data,
  output logic        tx_valid,
  input  logic        tx_ready,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  output logic        rx_ready
);

  logic [7:0]  w_offset;
  logic        w_hit;
  logic        w_rdEn;
  logic        w_wrEn;
  logic        w_txPush;
  logic        w_rxPop;
  logic        w_rxPush;
  logic        w_statusRd;
  logic        w_cntClr;
  logic        w_txFull;
  logic        w_txEmpty;
  logic        w_rxFull;
  logic        w_rxEmpty;
  logic [7:0]  w_rxHead;
  logic [31:0] w_status;
  logic [31:0] w_readData;
  logic        w_unusedBits;
  logic        r_txOverflow;
  logic [31:0] r_cycleCnt;
  logic [31:0] r_instretCnt;

  // Only the region tag and the low offset byte take part in decoding.
  assign w_unusedBits = ^{addr[27:8], wdata[31:8]};

  assign w_offset   = addr[7:0];
  assign w_hit      = (addr[31:28] == MMIO_REGION);
  assign w_rdEn     = re && w_hit;
  assign w_wrEn     = we && w_hit;
  assign w_txPush   = w_wrEn && (w_offset == MMIO_TX);
  assign w_rxPop    = w_rdEn && (w_offset == MMIO_RX);
  assign w_statusRd = w_rdEn && (w_offset == MMIO_STATUS);
  assign w_cntClr   = w_wrEn && (w_offset == MMIO_CNT_RST);

  // Handshakes are held low while reset is asserted so nothing moves
  // during the reset cycle itself.
  assign tx_valid = !w_txEmpty && !rst;
  assign rx_ready = !w_rxFull && !rst;
  assign w_rxPush = rx_valid && rx_ready;

  sync_fifo #(.WIDTH(8), .DEPTH(TX_DEPTH)) u_txFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_txPush),
    .pop   (tx_ready),
    .din   (wdata[7:0]),
    .dout  (tx_data),
    .full  (w_txFull),
    .empty (w_txEmpty)
  );

  sync_fifo #(.WIDTH(8), .DEPTH(RX_DEPTH)) u_rxFifo (
    .clk   (clk),
    .rst   (rst),
    .push  (w_rxPush),
    .pop   (w_rxPop),
    .din   (rx_data),
    .dout  (w_rxHead),
    .full  (w_rxFull),
    .empty (w_rxEmpty)
  );

  // Assemble the status word from start-of-cycle FIFO state.
  always_comb begin
    w_status                    = '0;
    w_status[STAT_TX_NOT_FULL]  = !w_txFull;
    w_status[STAT_RX_NOT_EMPTY] = !w_rxEmpty;
    w_status[STAT_TX_OVERFLOW]  = r_txOverflow;
  end

  // Load data mux; unmapped offsets and an empty RX FIFO read as zero.
  always_comb begin
    w_readData = '0;
    case (w_offset)
      MMIO_STATUS:  w_readData = w_status;
      MMIO_RX:      w_readData = w_rxEmpty ? 32'd0 : {24'd0, w_rxHead};
      MMIO_CYCLE:   w_readData = r_cycleCnt;
      MMIO_INSTRET: w_readData = r_instretCnt;
      default:      w_readData = '0;
    endcase
  end

  // Register load data one cycle after re; hold it between loads.
  always_ff @(posedge clk) begin
    if (rst)         rdata <= '0;
    else if (w_rdEn) rdata <= w_readData;
  end

  // Sticky TX overflow: a refused push sets it and wins over a status-read clear.
  always_ff @(posedge clk) begin
    if (rst)                       r_txOverflow <= 1'b0;
    else if (w_txPush && w_txFull) r_txOverflow <= 1'b1;
    else if (w_statusRd)           r_txOverflow <= 1'b0;
  end

  // Free-running counters; a counter-reset store beats the increment.
  always_ff @(posedge clk) begin
    if (rst || w_cntClr) begin
      r_cycleCnt   <= '0;
      r_instretCnt <= '0;
    end else begin
      r_cycleCnt   <= r_cycleCnt + 32'd1;
      r_instretCnt <= r_instretCnt + {31'd0, inst_retired};
    end
  end

endmodule
